logic_gates_checker: RTL
========================

// Module: logic_gates_checker
// PURPOSE
//   Hardware self-check engine for the two-input logic_gates block. Drives a/b
//   through all four input vectors, waits a settle window, samples the seven
//   gate outputs and compares them with golden values. Accumulates mismatches and
//   reports done/pass, making it the response-checking end of the gate stimulus path.
// PARAMETERS
//   SETTLE_CYCLES  1  cycles between driving a vector and sampling outputs (0 allowed)
//   ERR_W          5  width of err_count; saturating mismatch-bit counter (max 28 needed)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      reset, synchronous, active-low
//   start      in   1      begin a sweep; honoured only in IDLE or DONE
//   and_gate   in   1      DUT output, golden a&b   (fail_vec[0])
//   or_gate    in   1      DUT output, golden a|b   (fail_vec[1])
//   not_gate   in   1      DUT output, golden ~a    (fail_vec[2])
//   nand_gate  in   1      DUT output, golden ~(a&b) (fail_vec[3])
//   nor_gate   in   1      DUT output, golden ~(a|b) (fail_vec[4])
//   xor_gate   in   1      DUT output, golden a^b   (fail_vec[5])
//   xnor_gate  in   1      DUT output, golden ~(a^b) (fail_vec[6])
//   a, b       out  1      registered stimulus to DUT; {a,b} = vector index
//   busy       out  1      high from DRIVE of vector 0 through last CHECK
//   done       out  1      high in DONE; held until next accepted start or reset
//   pass       out  1      high in DONE iff err_count==0; 0 otherwise
//   err_count  out  ERR_W  total mismatched output bits this sweep, saturating
//   fail_vec   out  7      sticky per-gate mismatch flags this sweep
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; a,b,busy,done,pass,err_count,fail_vec,
//     vector idx, settle counter all 0. Reset mid-sweep aborts immediately; no result.
//   FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
//   IDLE/DONE + start=1: clear err_count, fail_vec, idx=0, done=0, pass=0 -> DRIVE.
//   DRIVE (1 cycle): a<=idx[1], b<=idx[0]; busy=1; -> SETTLE (load counter) or,
//     if SETTLE_CYCLES==0, -> CHECK.
//   SETTLE: exactly SETTLE_CYCLES cycles, then -> CHECK.
//   CHECK (1 cycle): compute 7-bit mismatch m = outputs ^ golden(a,b);
//     fail_vec |= m; err_count += popcount(m), clamped at 2^ERR_W-1.
//     idx==3 -> DONE; else idx++ -> DRIVE.
//   DONE: busy=0, done=1, pass=(err_count==0); a,b hold last vector (1,1).
//   Timing: start accepted at edge T -> DRIVE in cycle T+1; each vector takes
//     SETTLE_CYCLES+2 cycles; done rises at edge T+1+4*(SETTLE_CYCLES+2).
//   start while busy: ignored, no effect on sweep or results.
//   Results (err_count, fail_vec) stable in DONE; updated only in CHECK.
//   Inputs are sampled only in CHECK; X/changes elsewhere are don't-care.
// TESTING
//   1. Correct gate model, SETTLE=1, start pulse at cycle 0 -> a,b step 00,01,10,11;
//      done=1 at cycle 13, pass=1, err_count=0, fail_vec=0.
//   2. xor_gate stuck at 0 -> err_count=2 (vectors 01,10), fail_vec=7'b010_0000, pass=0.
//   3. not_gate wired as ~b -> mismatches at 01,10: err_count=2, fail_vec=7'b000_0100.
//   4. Assert start again at cycle 5 of a sweep -> ignored; done still at cycle 13;
//      second start in DONE clears results and re-runs identically.
//   5. rst_n=0 during SETTLE of vector 2 -> next cycle all outputs 0, state IDLE;
//      new start gives a clean full sweep.
//   6. ERR_W=3, all seven outputs inverted -> 28 mismatches, err_count saturates at 7,
//      fail_vec=7'h7F; SETTLE=0 variant -> done at cycle 9.

Source files
------------

// File: rtl/logic_gates_checker.sv
// Self-check engine for the two-input logic_gates block: sweeps all four a/b vectors,
// compares the seven gate outputs against golden values and reports pass/fail.
module logic_gates_checker #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             and_gate,
   input  logic             or_gate,
   input  logic             not_gate,
   input  logic             nand_gate,
   input  logic             nor_gate,
   input  logic             xor_gate,
   input  logic             xnor_gate,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [6:0]       fail_vec
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
   // Extra headroom so err_count + 7 never wraps before the clamp
   localparam int unsigned SUM_W = ERR_W + 3;
   localparam logic [SUM_W-1:0] ERR_MAX = {3'b000, {ERR_W{1'b1}}};

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

   state_e           state_q;
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;

   logic [6:0]       dut_out;
   logic [6:0]       golden;
   logic [6:0]       mismatch;
   logic [SUM_W-1:0] pop;
   logic [SUM_W-1:0] sum;
   logic [ERR_W-1:0] err_next;

   always_comb begin
      dut_out  = {xnor_gate, xor_gate, nor_gate, nand_gate, not_gate, or_gate, and_gate};
      golden   = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
      mismatch = dut_out ^ golden;
      pop      = '0;
      for (int i = 0; i < 7; i++) begin
         pop = pop + SUM_W'(mismatch[i]);
      end
      sum      = {3'b000, err_count} + pop;
      err_next = (sum > ERR_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         cnt_q     <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= 7'd0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  err_count <= '0;
                  fail_vec  <= 7'd0;
                  idx_q     <= 2'd0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state_q   <= StDrive;
               end
            end
            StDrive: begin
               a <= idx_q[1];
               b <= idx_q[0];
               if (SETTLE_CYCLES == 0) begin
                  state_q <= StCheck;
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= StSettle;
               end
            end
            StSettle: begin
               if (cnt_q == '0) begin
                  state_q <= StCheck;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StCheck: begin
               fail_vec  <= fail_vec | mismatch;
               err_count <= err_next;
               if (idx_q == 2'd3) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_next == '0);
                  state_q <= StDone;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= StDrive;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
